batch_loader: RTL and testbench



---
 rtl/batch_loader.sv | 145 ++++++++++++++
 tb/tb_batch_loader.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/batch_loader.sv
// batch_loader: packs a byte stream into 32-bit LE words, writes batches to BRAM port B.
// Optional per-batch XOR checksum byte when BATCH_LOADER_CHECKSUM_EN is defined.
module batch_loader #(
  parameter int WORD_COUNT = 8,
  parameter int CNT_W = $clog2(WORD_COUNT) + 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  input  logic        OutOfData,
  output logic [31:0] addrB,
  output logic [31:0] dataB,
  output logic [3:0]  weB,
  output logic        DONE_WRITING,
  output logic        chk_error
);
  typedef enum logic [2:0] {
    FILL,
    LAST_WR,
    SIGNAL,
    WAIT_BUSY,
    WAIT_FREE
  } state_t;

  state_t state, next;
  logic [1:0] byte_cnt;
  logic [CNT_W-1:0] word_cnt;
  logic [23:0] acc;
  logic take, data_take, word_end, chk_clr;

  assign take = byte_valid & byte_ready;
  assign word_end = data_take & (byte_cnt == 2'd3);

`ifdef BATCH_LOADER_CHECKSUM_EN
  localparam logic [CNT_W-1:0] FULL = CNT_W'(WORD_COUNT);
  logic [7:0] xsum;
  logic chk_take, chk_ok;
  assign chk_take = take & (word_cnt == FULL);
  assign chk_ok = (xsum == byte_data);
  assign data_take = take & ~chk_take;
  assign chk_clr = chk_take & ~chk_ok;
`else
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_COUNT - 1);
  assign data_take = take;
  assign chk_clr = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= FILL;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next = state;
    unique case (state)
      FILL: begin
`ifdef BATCH_LOADER_CHECKSUM_EN
        if (chk_take && chk_ok) next = SIGNAL;
`else
        if (word_end && word_cnt == LAST) next = LAST_WR;
`endif
      end
      LAST_WR:   next = SIGNAL;
      SIGNAL:    next = WAIT_BUSY;
      WAIT_BUSY: if (!OutOfData) next = WAIT_FREE;
      WAIT_FREE: if (OutOfData) next = FILL;
      default:   next = FILL;
    endcase
  end

  always_comb begin
    byte_ready = (state == FILL);
  end

  // The 4th byte bypasses acc straight into the write register.
  always_ff @(posedge clock) begin
    if (reset) begin
      byte_cnt <= '0;
      word_cnt <= '0;
      acc      <= '0;
    end else begin
      if (data_take) begin
        byte_cnt <= byte_cnt + 2'd1;
        case (byte_cnt)
          2'd0:    acc[7:0]   <= byte_data;
          2'd1:    acc[15:8]  <= byte_data;
          2'd2:    acc[23:16] <= byte_data;
          default: ;
        endcase
      end
      if (word_end) word_cnt <= word_cnt + CNT_W'(1);
      if (state == SIGNAL || chk_clr) word_cnt <= '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addrB <= '0;
      dataB <= '0;
      weB   <= 4'h0;
    end else begin
      weB <= 4'h0;
      if (word_end) begin
        weB   <= 4'hF;
        addrB <= 32'(word_cnt) << 2;
        dataB <= {byte_data, acc};
      end
    end
  end

`ifdef BATCH_LOADER_CHECKSUM_EN
  // Match skips LAST_WR, so the pulse trails SIGNAL by a cycle
  // to keep the 2-cycle latency from the checksum byte.
  always_ff @(posedge clock) begin
    if (reset) begin
      DONE_WRITING <= 1'b0;
      xsum         <= '0;
      chk_error    <= 1'b0;
    end else begin
      DONE_WRITING <= (state == SIGNAL);
      if (state == SIGNAL || chk_clr) begin
        xsum <= '0;
      end else if (data_take) begin
        xsum <= xsum ^ byte_data;
      end
      if (chk_clr) chk_error <= 1'b1;
    end
  end
`else
  always_ff @(posedge clock) begin
    if (reset) begin
      DONE_WRITING <= 1'b0;
    end else begin
      DONE_WRITING <= (next == SIGNAL);
    end
  end

  assign chk_error = 1'b0;
`endif
endmodule

// File: tb/tb_batch_loader.sv
// tb_batch_loader: random and directed batches checked against a word-level model.
// Covers gaps, OutOfData handshake, reset mid-batch, back-to-back accept, checksum.
`timescale 1ns/1ps
module tb_batch_loader;
  localparam int WC = 8;
  localparam int NB = 4 * WC;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic OutOfData = 1'b1;
  logic byte_ready;
  logic [31:0] addrB;
  logic [31:0] dataB;
  logic [3:0] weB;
  logic DONE_WRITING;
  logic chk_error;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int acc_cyc[$];
  logic [7:0] acc_b[$];
  logic [31:0] wr_a[$];
  logic [31:0] wr_d[$];
  logic [3:0] wr_w[$];
  int wr_c[$];
  int done_c[$];

  batch_loader #(.WORD_COUNT(WC)) dut (
    .clock(clock),
    .reset(reset),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .byte_ready(byte_ready),
    .OutOfData(OutOfData),
    .addrB(addrB),
    .dataB(dataB),
    .weB(weB),
    .DONE_WRITING(DONE_WRITING),
    .chk_error(chk_error)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (!reset && byte_valid && byte_ready) begin
      acc_cyc.push_back(cyc);
      acc_b.push_back(byte_data);
    end
    if (weB != 4'h0) begin
      wr_a.push_back(addrB);
      wr_d.push_back(dataB);
      wr_w.push_back(weB);
      wr_c.push_back(cyc);
    end
    if (DONE_WRITING) done_c.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    acc_cyc.delete();
    acc_b.delete();
    wr_a.delete();
    wr_d.delete();
    wr_w.delete();
    wr_c.delete();
    done_c.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    byte_valid = 1'b0;
    tick(2);
    @(negedge clock);
    chk("rst_ready", byte_ready, 1);
    chk("rst_addr", addrB, 0);
    chk("rst_data", dataB, 0);
    chk("rst_we", weB, 0);
    chk("rst_done", DONE_WRITING, 0);
    chk("rst_chkerr", chk_error, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int t = 0;
    repeat (gap) begin
      byte_valid = 1'b0;
      @(posedge clock);
      #1;
    end
    byte_valid = 1'b1;
    byte_data = b;
    @(negedge clock);
    while (!byte_ready && t < 100) begin
      @(negedge clock);
      t++;
    end
    if (t >= 100) chk("ready_timeout", 0, 1);
    @(posedge clock);
    #1;
    byte_valid = 1'b0;
  endtask

  function automatic logic [7:0] xor_of(input logic [7:0] b[$]);
    logic [7:0] x = 8'h00;
    foreach (b[i]) x ^= b[i];
    return x;
  endfunction

  task automatic check_batch(input logic [7:0] b[$]);
    logic [31:0] exp_d;
    int nacc;
    int last;
`ifdef BATCH_LOADER_CHECKSUM_EN
    nacc = NB + 1;
`else
    nacc = NB;
`endif
    chk("n_writes", wr_a.size(), WC);
    chk("n_accepts", acc_b.size(), nacc);
    for (int k = 0; k < WC; k++) begin
      if (k < wr_a.size()) begin
        exp_d = {b[4*k+3], b[4*k+2], b[4*k+1], b[4*k]};
        chk("wr_addr", wr_a[k], 4 * k);
        chk("wr_data", wr_d[k], exp_d);
        chk("wr_we", wr_w[k], 4'hF);
        if (acc_cyc.size() > 4 * k + 3)
          chk("wr_latency", wr_c[k], acc_cyc[4*k+3] + 1);
      end
    end
    chk("n_done", done_c.size(), 1);
    if (done_c.size() > 0 && acc_cyc.size() == nacc) begin
      last = acc_cyc[nacc-1];
      chk("done_latency", done_c[0], last + 2);
    end
  endtask

  task automatic run_batch(input logic [7:0] b[$], input int mode);
    int g;
    clear_logs();
    foreach (b[i]) begin
      g = (mode == 0) ? 0 : (mode == 1) ? 1 : $urandom_range(0, 3);
      send(b[i], g);
    end
`ifdef BATCH_LOADER_CHECKSUM_EN
    send(xor_of(b), 0);
`endif
    tick(4);
    check_batch(b);
  endtask

  task automatic handshake(input int hold, input int lo);
    int n0;
    n0 = acc_b.size();
    byte_valid = 1'b1;
    byte_data = 8'h5A;
    OutOfData = 1'b1;
    repeat (hold) begin
      @(negedge clock);
      chk("ready_busy", byte_ready, 0);
      tick(1);
    end
    OutOfData = 1'b0;
    repeat (lo) begin
      @(negedge clock);
      chk("ready_serving", byte_ready, 0);
      tick(1);
    end
    byte_valid = 1'b0;
    OutOfData = 1'b1;
    @(negedge clock);
    chk("ready_edge", byte_ready, 0);
    tick(1);
    @(negedge clock);
    chk("ready_free", byte_ready, 1);
    chk("no_consume", acc_b.size(), n0);
    tick(1);
  endtask

  task automatic rand_bytes(output logic [7:0] b[$]);
    b.delete();
    for (int i = 0; i < NB; i++) b.push_back(8'($urandom_range(0, 255)));
  endtask

  initial begin
    logic [7:0] bq[$];

    do_reset();
    clear_logs();

    for (int i = 0; i < NB; i++) bq.push_back(8'(i));
    run_batch(bq, 0);
    if (wr_d.size() == WC) begin
      chk("first_data", wr_d[0], 32'h03020100);
      chk("last_addr", wr_a[WC-1], 32'h1C);
      chk("last_data", wr_d[WC-1], 32'h1F1E1D1C);
    end
    handshake(5, 20);

    run_batch(bq, 1);
    handshake(1, 2);

    rand_bytes(bq);
    run_batch(bq, 1);
    handshake(1, 3);

    rand_bytes(bq);
    run_batch(bq, 2);
    handshake(2, 1);

    clear_logs();
    for (int i = 0; i < 6; i++) send(8'($urandom_range(0, 255)), 0);
    chk("partial_w0", wr_a.size(), 1);
    clear_logs();
    do_reset();
    tick(3);
    chk("partial_nowr", wr_a.size(), 0);
    chk("partial_nodone", done_c.size(), 0);
    rand_bytes(bq);
    run_batch(bq, 2);
    handshake(1, 2);

    rand_bytes(bq);
    bq[4] = 8'hAA;
    run_batch(bq, 0);
    if (wr_c.size() > 1 && acc_cyc.size() > 4) begin
      chk("aa_same_cycle", wr_c[0], acc_cyc[4]);
      chk("aa_low_byte", {24'h0, wr_d[1][7:0]}, 32'hAA);
    end
    handshake(1, 2);

`ifdef BATCH_LOADER_CHECKSUM_EN
    clear_logs();
    bq.delete();
    for (int i = 0; i < NB; i++) bq.push_back(8'(i));
    foreach (bq[i]) send(bq[i], 0);
    send(8'h55, 0);
    @(negedge clock);
    chk("bad_ready", byte_ready, 1);
    chk("bad_chkerr", chk_error, 1);
    tick(4);
    chk("bad_nodone", done_c.size(), 0);
    chk("bad_sticky", chk_error, 1);
    do_reset();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
